transform_sequencer: RTL and testbench

Parametrised multi-model controller for the transform stage. It steps through up to `MAX_MODEL_COUNT` models in one frame. For each model it fetches an MVP matrix, runs the vertex shader and post-processor pass, then runs the primitive assembler pass. It sits between the frame scheduler and the VS/VPP, G-buffer and PA datapath, and owns every G-buffer write address. Vertices of successive models are packed at increasing base addresses. Clip-invalid vertices keep their slot, so index data stays aligned.

---
 rtl/transform_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_transform_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transform_sequencer.sv
// transform_sequencer: frame-level controller that steps each model through the MVP fetch,
// the vertex shade pass that packs the G-buffer, and the primitive assembly pass.
module transform_sequencer #(
    parameter int unsigned MAX_MODEL_COUNT      = 16,
    parameter int unsigned MAX_VERTEX_COUNT     = 4096,
    parameter int unsigned MAX_TRIANGLE_COUNT   = 16384,
    parameter int unsigned RESET_BASE_PER_MODEL = 0,
    localparam int unsigned AW = $clog2(MAX_VERTEX_COUNT),
    localparam int unsigned TW = $clog2(MAX_TRIANGLE_COUNT + 1),
    localparam int unsigned CW = $clog2(MAX_MODEL_COUNT + 1),
    localparam int unsigned IW = $clog2(MAX_MODEL_COUNT)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [CW-1:0] i_model_count,
    output logic          o_ready,
    output logic          o_done,
    output logic          o_error,
    output logic          o_mvp_read_en,
    input  logic          i_mvp_dv,
    output logic          o_vs_start,
    input  logic          i_vpp_vertex_dv,
    input  logic          i_vpp_vertex_invalid,
    input  logic          i_vpp_last,
    output logic          o_gbuff_write_en,
    output logic [AW-1:0] o_gbuff_addr_write,
    output logic          o_gbuff_write_invalid,
    output logic [AW-1:0] o_vertex_base,
    output logic          o_pa_start,
    input  logic          i_pa_finished,
    input  logic          i_tri_dv,
    output logic [IW-1:0] o_model_idx,
    output logic [TW-1:0] o_triangle_count
);

    // Local count is one bit wider than an address and saturates, so once a model
    // runs past the buffer end it can never wrap back into range.
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = AW + 2;

    typedef enum logic [2:0] {
        StIdle,
        StGetMatrix,
        StShade,
        StAssemble,
        StNextModel,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] base_q, base_d;
    logic [LW-1:0] local_q, local_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] tri_q, tri_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          winv_q, winv_d;
    logic          vs_q, vs_d;
    logic          pa_q, pa_d;

    logic [SW-1:0] sum;
    logic          overflow;
    logic [LW-1:0] local_inc;
    logic [TW-1:0] tri_inc;
    logic          last_model;

    always_comb begin
        sum        = {2'b00, base_q} + {1'b0, local_q};
        overflow   = (sum >= SW'(MAX_VERTEX_COUNT));
        local_inc  = (local_q == {LW{1'b1}}) ? local_q : local_q + LW'(1);
        tri_inc    = (tri_q >= TW'(MAX_TRIANGLE_COUNT)) ? tri_q : tri_q + TW'(1);
        last_model = (CW'(idx_q) == count_q - CW'(1));
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        base_d  = base_q;
        local_d = local_q;
        idx_d   = idx_q;
        tri_d   = tri_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        winv_d  = winv_q;

        if (i_abort && (state_q != StIdle)) begin
            // Counters keep their values for inspection until the next start.
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        count_d = i_model_count;
                        base_d  = '0;
                        local_d = '0;
                        idx_d   = '0;
                        tri_d   = '0;
                        err_d   = 1'b0;
                        state_d = (i_model_count == '0) ? StDone : StGetMatrix;
                    end
                end
                StGetMatrix: begin
                    if (i_mvp_dv) begin
                        state_d = StShade;
                    end
                end
                StShade: begin
                    if (i_vpp_vertex_dv) begin
                        local_d = local_inc;
                        if (overflow) begin
                            err_d = 1'b1;
                        end else begin
                            we_d    = 1'b1;
                            waddr_d = sum[AW-1:0];
                            winv_d  = i_vpp_vertex_invalid;
                        end
                        if (i_vpp_last) begin
                            state_d = StAssemble;
                        end
                    end
                end
                StAssemble: begin
                    if (i_tri_dv) begin
                        tri_d = tri_inc;
                    end
                    if (i_pa_finished) begin
                        state_d = StNextModel;
                    end
                end
                StNextModel: begin
                    base_d  = (RESET_BASE_PER_MODEL != 0) ? '0 : sum[AW-1:0];
                    local_d = '0;
                    idx_d   = idx_q + IW'(1);
                    state_d = last_model ? StDone : StGetMatrix;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        vs_d = (state_d == StShade) && (state_q != StShade);
        pa_d = (state_d == StAssemble) && (state_q != StAssemble);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            count_q <= '0;
            base_q  <= '0;
            local_q <= '0;
            idx_q   <= '0;
            tri_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            winv_q  <= 1'b0;
            vs_q    <= 1'b0;
            pa_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            base_q  <= base_d;
            local_q <= local_d;
            idx_q   <= idx_d;
            tri_q   <= tri_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            winv_q  <= winv_d;
            vs_q    <= vs_d;
            pa_q    <= pa_d;
        end
    end

    assign o_ready               = (state_q == StIdle);
    assign o_mvp_read_en         = (state_q == StGetMatrix);
    assign o_done                = (state_q == StDone);
    assign o_error               = err_q;
    assign o_vs_start            = vs_q;
    assign o_pa_start            = pa_q;
    assign o_gbuff_write_en      = we_q;
    assign o_gbuff_addr_write    = waddr_q;
    assign o_gbuff_write_invalid = winv_q;
    assign o_vertex_base         = base_q;
    assign o_model_idx           = idx_q;
    assign o_triangle_count      = tri_q;

endmodule

// File: tb/tb_transform_sequencer.sv
// Bench for transform_sequencer: a default instance and a small-buffer / saturating /
// base-reset instance driven by shared stimulus and checked against a frame-level model.
module tb_transform_sequencer;

    logic clk = 1'b0;
    logic rstn;
    logic start, abort, mvp_dv, vdv, vinv, vlast, pa_fin, tri_dv;
    logic [4:0] mcount;

    logic a_ready, a_done, a_err, a_mrd, a_vs, a_we, a_inv, a_pa;
    logic [11:0] a_addr, a_base;
    logic [3:0]  a_idx;
    logic [14:0] a_tri;

    logic b_ready, b_done, b_err, b_mrd, b_vs, b_we, b_inv, b_pa;
    logic [2:0] b_addr, b_base;
    logic [3:0] b_idx;
    logic [1:0] b_tri;

    always #5 clk = ~clk;

    transform_sequencer dut_a (
        .clk(clk), .rstn(rstn), .i_start(start), .i_abort(abort), .i_model_count(mcount),
        .o_ready(a_ready), .o_done(a_done), .o_error(a_err), .o_mvp_read_en(a_mrd),
        .i_mvp_dv(mvp_dv), .o_vs_start(a_vs), .i_vpp_vertex_dv(vdv),
        .i_vpp_vertex_invalid(vinv), .i_vpp_last(vlast), .o_gbuff_write_en(a_we),
        .o_gbuff_addr_write(a_addr), .o_gbuff_write_invalid(a_inv), .o_vertex_base(a_base),
        .o_pa_start(a_pa), .i_pa_finished(pa_fin), .i_tri_dv(tri_dv), .o_model_idx(a_idx),
        .o_triangle_count(a_tri)
    );

    transform_sequencer #(
        .MAX_MODEL_COUNT(16), .MAX_VERTEX_COUNT(8), .MAX_TRIANGLE_COUNT(3),
        .RESET_BASE_PER_MODEL(1)
    ) dut_b (
        .clk(clk), .rstn(rstn), .i_start(start), .i_abort(abort), .i_model_count(mcount),
        .o_ready(b_ready), .o_done(b_done), .o_error(b_err), .o_mvp_read_en(b_mrd),
        .i_mvp_dv(mvp_dv), .o_vs_start(b_vs), .i_vpp_vertex_dv(vdv),
        .i_vpp_vertex_invalid(vinv), .i_vpp_last(vlast), .o_gbuff_write_en(b_we),
        .o_gbuff_addr_write(b_addr), .o_gbuff_write_invalid(b_inv), .o_vertex_base(b_base),
        .o_pa_start(b_pa), .i_pa_finished(pa_fin), .i_tri_dv(tri_dv), .o_model_idx(b_idx),
        .o_triangle_count(b_tri)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed activity, sampled on the falling edge.
    int aw_q[$], bw_q[$], ab_q[$], bb_q[$], ai_q[$], bi_q[$];
    int a_vs_n, a_pa_n, a_done_n, b_vs_n, b_pa_n, b_done_n;

    always @(negedge clk) begin
        if (rstn) begin
            if (a_we) aw_q.push_back(int'({a_inv, a_addr}));
            if (b_we) bw_q.push_back(int'({b_inv, b_addr}));
            if (a_pa) begin ab_q.push_back(int'(a_base)); ai_q.push_back(int'(a_idx)); end
            if (b_pa) begin bb_q.push_back(int'(b_base)); bi_q.push_back(int'(b_idx)); end
            a_vs_n += int'(a_vs);  a_pa_n += int'(a_pa);  a_done_n += int'(a_done);
            b_vs_n += int'(b_vs);  b_pa_n += int'(b_pa);  b_done_n += int'(b_done);
        end
    end

    // Frame description and reference results.
    int          f_n;
    int          f_v[16];
    int          f_t[16];
    logic [15:0] f_inv[16];
    bit          f_coin[16];

    int ew_a[$], ew_b[$], eb_a[$], eb_b[$];
    int etri[2];
    bit eerr[2];
    bit eerr_at[2][16][16];

    task automatic model(input int k, input int maxv, input int maxt, input int rb,
                         input int aw);
        int base = 0;
        int tri_n = 0;
        bit err = 1'b0;
        int w;
        for (int m = 0; m < f_n; m++) begin
            for (int v = 0; v < f_v[m]; v++) begin
                if (base + v < maxv) begin
                    w = (int'(f_inv[m][v]) << aw) | (base + v);
                    if (k == 0) ew_a.push_back(w); else ew_b.push_back(w);
                end else begin
                    err = 1'b1;
                end
                eerr_at[k][m][v] = err;
            end
            if (k == 0) eb_a.push_back(base); else eb_b.push_back(base);
            tri_n = (tri_n + f_t[m] > maxt) ? maxt : tri_n + f_t[m];
            base = (rb != 0) ? 0 : (base + f_v[m]) % (1 << aw);
        end
        etri[k] = tri_n;
        eerr[k] = err;
    endtask

    task automatic clear_obs();
        aw_q.delete(); bw_q.delete(); ab_q.delete(); bb_q.delete();
        ai_q.delete(); bi_q.delete();
        a_vs_n = 0; a_pa_n = 0; a_done_n = 0; b_vs_n = 0; b_pa_n = 0; b_done_n = 0;
    endtask

    task automatic run_frame(input bit poke);
        int budget;
        ew_a.delete(); ew_b.delete(); eb_a.delete(); eb_b.delete();
        model(0, 4096, 16384, 0, 12);
        model(1, 8, 3, 1, 3);
        clear_obs();
        mcount = 5'(f_n);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_clear_a", a_err, 0);
        check("err_clear_b", b_err, 0);
        for (int m = 0; m < f_n; m++) begin
            budget = 0;
            while (!a_mrd && budget < 50) begin tick(); budget++; end
            check("mvp_req", a_mrd, 1);
            if (!a_mrd) begin abort = 1'b1; tick(); abort = 1'b0; return; end
            repeat ($urandom_range(0, 3)) tick();
            mvp_dv = 1'b1; tick(); mvp_dv = 1'b0;
            for (int v = 0; v < f_v[m]; v++) begin
                repeat ($urandom_range(0, 2)) tick();
                vdv = 1'b1;
                vinv = f_inv[m][v];
                vlast = (v == f_v[m] - 1);
                if (poke && m == 0 && v == 0) begin
                    start = 1'b1;
                    mcount = 5'(f_n + 2);
                end
                tick();
                vdv = 1'b0; vinv = 1'b0; vlast = 1'b0; start = 1'b0;
                check("err_a", a_err, eerr_at[0][m][v]);
                check("err_b", b_err, eerr_at[1][m][v]);
            end
            for (int t = 0; t < f_t[m]; t++) begin
                repeat ($urandom_range(0, 2)) tick();
                tri_dv = 1'b1;
                if (t == f_t[m] - 1 && f_coin[m]) pa_fin = 1'b1;
                tick();
                tri_dv = 1'b0; pa_fin = 1'b0;
            end
            if (!(f_t[m] > 0 && f_coin[m])) begin
                repeat ($urandom_range(0, 2)) tick();
                pa_fin = 1'b1; tick(); pa_fin = 1'b0;
            end
        end
        check("done_early", a_done, 0);
        tick();
        check("done_a", a_done, 1);
        check("done_b", b_done, 1);
        tick();
        check("ready_after_a", a_ready, 1);
        check("done_one_a", a_done_n, 1);
        check("done_one_b", b_done_n, 1);
        check("vs_pulses", a_vs_n, f_n);
        check("pa_pulses", a_pa_n, f_n);
        check("tri_a", a_tri, etri[0]);
        check("tri_b", b_tri, etri[1]);
        check("err_end_a", a_err, eerr[0]);
        check("err_end_b", b_err, eerr[1]);
        check("nwr_a", aw_q.size(), ew_a.size());
        check("nwr_b", bw_q.size(), ew_b.size());
        for (int i = 0; i < aw_q.size() && i < ew_a.size(); i++) check("wr_a", aw_q[i], ew_a[i]);
        for (int i = 0; i < bw_q.size() && i < ew_b.size(); i++) check("wr_b", bw_q[i], ew_b[i]);
        check("nbase_a", ab_q.size(), eb_a.size());
        for (int i = 0; i < ab_q.size() && i < eb_a.size(); i++) begin
            check("base_a", ab_q[i], eb_a[i]);
            check("idx_a", ai_q[i], i);
        end
        for (int i = 0; i < bb_q.size() && i < eb_b.size(); i++) begin
            check("base_b", bb_q[i], eb_b[i]);
            check("idx_b", bi_q[i], i);
        end
    endtask

    typedef struct {
        int start, mvp, vdv, vinv, vlast, tri_dv, fin;
        int ready, mrd, vs, we, pa, done, addr, winv, tcnt;
    } row_t;

    row_t tbl[19];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        int st;
        rstn = 1'b0;
        start = 0; abort = 0; mvp_dv = 0; vdv = 0; vinv = 0; vlast = 0; pa_fin = 0;
        tri_dv = 0; mcount = 5'd1;
        #1;
        check("rst_ready", a_ready, 1);
        check("rst_outs_a", {a_mrd, a_done, a_err, a_vs, a_we, a_pa, |a_addr, |a_base,
                             |a_idx, |a_tri}, 0);
        #11 rstn = 1'b1;
        tick();
        check("post_rst_ready", a_ready, 1);

        // Single model, exact cycle timing.
        tbl[0] = '{1,0,0,0,0,0,0, 0,1,0,0,0,0, 0,0,0};
        tbl[1] = '{0,0,0,0,0,0,0, 0,1,0,0,0,0, 0,0,0};
        tbl[2] = '{0,0,0,0,0,0,0, 0,1,0,0,0,0, 0,0,0};
        tbl[3] = '{0,1,0,0,0,0,0, 0,0,1,0,0,0, 0,0,0};
        for (int v = 0; v < 8; v++)
            tbl[4+v] = '{0,0,1,int'(v==2),int'(v==7),0,0, 0,0,0,1,int'(v==7),0, v,int'(v==2),0};
        tbl[12] = '{0,0,0,0,0,1,0, 0,0,0,0,0,0, 0,0,1};
        tbl[13] = '{0,0,0,0,0,1,0, 0,0,0,0,0,0, 0,0,2};
        tbl[14] = '{0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,2};
        tbl[15] = '{0,0,0,0,0,1,0, 0,0,0,0,0,0, 0,0,3};
        tbl[16] = '{0,0,0,0,0,1,1, 0,0,0,0,0,0, 0,0,4};
        tbl[17] = '{0,0,0,0,0,0,0, 0,0,0,0,0,1, 0,0,4};
        tbl[18] = '{0,0,0,0,0,0,0, 1,0,0,0,0,0, 0,0,4};
        for (int i = 0; i < 19; i++) begin
            start = (tbl[i].start != 0);  mvp_dv = (tbl[i].mvp != 0);
            vdv = (tbl[i].vdv != 0);      vinv = (tbl[i].vinv != 0);
            vlast = (tbl[i].vlast != 0);  tri_dv = (tbl[i].tri_dv != 0);
            pa_fin = (tbl[i].fin != 0);
            tick();
            check($sformatf("row%0d_ctl", i), {a_ready, a_mrd, a_vs, a_we, a_pa, a_done},
                  {tbl[i].ready[0], tbl[i].mrd[0], tbl[i].vs[0], tbl[i].we[0],
                   tbl[i].pa[0], tbl[i].done[0]});
            if (tbl[i].we != 0) begin
                check($sformatf("row%0d_addr", i), a_addr, tbl[i].addr);
                check($sformatf("row%0d_inv", i), a_inv, tbl[i].winv);
            end
            check($sformatf("row%0d_tri", i), a_tri, tbl[i].tcnt);
        end
        start = 0; mvp_dv = 0; vdv = 0; vinv = 0; vlast = 0; tri_dv = 0; pa_fin = 0;

        // Three models 5/3/6 vertices.
        f_n = 3; f_v[0] = 5; f_v[1] = 3; f_v[2] = 6;
        for (int m = 0; m < 3; m++) begin f_t[m] = m + 1; f_inv[m] = '0; f_coin[m] = 0; end
        run_frame(1'b0);
        // Invalid vertex keeps its slot.
        f_n = 2; f_v[0] = 4; f_v[1] = 3; f_inv[0] = 16'h0004; f_inv[1] = '0;
        f_t[0] = 1; f_t[1] = 0;
        run_frame(1'b0);
        // Overflow on the small buffer instance.
        f_n = 1; f_v[0] = 10; f_inv[0] = 16'h0001; f_t[0] = 2;
        run_frame(1'b0);
        // Triangle saturation, last pulse coincident with finish; start poked mid-shade.
        f_n = 1; f_v[0] = 2; f_inv[0] = '0; f_t[0] = 5; f_coin[0] = 1;
        run_frame(1'b1);

        // Zero models.
        mcount = 5'd0; start = 1'b1; tick(); start = 1'b0;
        dn = int'(a_done); st = int'(a_mrd | a_vs | a_we | a_pa);
        for (int k = 0; k < 3; k++) begin
            tick();
            dn += int'(a_done); st += int'(a_mrd | a_vs | a_we | a_pa);
        end
        check("zero_done_pulses", dn, 1);
        check("zero_strobes", st, 0);
        check("zero_ready", a_ready, 1);

        // Abort during assembly.
        mcount = 5'd2; start = 1'b1; tick(); start = 1'b0;
        mvp_dv = 1'b1; tick(); mvp_dv = 1'b0;
        vdv = 1'b1; tick(); vlast = 1'b1; tick(); vdv = 1'b0; vlast = 1'b0;
        check("abort_pa_start", a_pa, 1);
        tri_dv = 1'b1; tick(); tri_dv = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_ready", a_ready, 1);
        check("abort_tri_kept", a_tri, 1);
        check("abort_idx_kept", a_idx, 0);
        dn = 0;
        for (int k = 0; k < 4; k++) begin dn += int'(a_done); tick(); end
        check("abort_no_done", dn, 0);

        // Reset asserted mid-shade.
        mcount = 5'd1; start = 1'b1; tick(); start = 1'b0;
        mvp_dv = 1'b1; tick(); mvp_dv = 1'b0;
        vdv = 1'b1; vinv = 1'b1; tick(); vdv = 1'b0; vinv = 1'b0;
        check("pre_rst_we", a_we, 1);
        #2 rstn = 1'b0;
        #1;
        check("midrst_ready", a_ready, 1);
        check("midrst_outs_a", {a_mrd, a_done, a_err, a_vs, a_we, a_inv, a_pa, |a_addr,
                                |a_base, |a_idx, |a_tri}, 0);
        check("midrst_outs_b", {b_mrd, b_done, b_we, b_inv, |b_addr, |b_tri}, 0);
        #3 rstn = 1'b1;
        tick();

        // Randomized frames.
        for (int fr = 0; fr < 30; fr++) begin
            f_n = $urandom_range(1, 4);
            for (int m = 0; m < f_n; m++) begin
                f_v[m] = $urandom_range(1, 12);
                f_t[m] = $urandom_range(0, 6);
                f_inv[m] = 16'($urandom);
                f_coin[m] = ($urandom_range(0, 1) == 1);
            end
            run_frame($urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
